// File: rtl/vip_sched_pkg.sv
// Shared types and constants for the multi-channel frame capture scheduler.
package vip_sched_pkg;

  localparam int N_CH   = 3;
  localparam int PIX_W  = 24;
  localparam int ADDR_W = 19;
  localparam int CH_W   = 2;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SELECT,
    S_ARM,
    S_CAPTURE,
    S_NEXT,
    S_FINISH
  } state_e;

  typedef struct packed {
    logic            found;
    logic [CH_W-1:0] idx;
  } pick_t;

  // Lowest set bit of the pending mask; found=0 when nothing is pending.
  function automatic pick_t pick_lowest(input logic [N_CH-1:0] pend);
    pick_t p;
    p = '0;
    for (int k = N_CH - 1; k >= 0; k--) begin
      if (pend[k]) begin
        p.found = 1'b1;
        p.idx   = CH_W'(k);
      end
    end
    return p;
  endfunction

endpackage

// File: rtl/vsync_fall_det.sv
// Registers one vsync line and flags its 1->0 transition in the current cycle.
module vsync_fall_det (
  input  logic clk,
  input  logic rst,
  input  logic vsync,
  output logic fall
);

  logic vs_q, vs_d;

  always_comb vs_d = vsync;

  always_ff @(posedge clk) begin
    if (rst) vs_q <= 1'b0;
    else     vs_q <= vs_d;
  end

  assign fall = vs_q & ~vsync;

endmodule

// File: rtl/frame_capture_sched.sv
// Captures one frame per selected channel, lowest channel first, into a shared
// frame-buffer write port with a fixed one-cycle write latency.
module frame_capture_sched
  import vip_sched_pkg::*;
#(
  parameter int IMG_HDISP = 640,
  parameter int IMG_VDISP = 480
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic                   abort,
  input  logic [N_CH-1:0]        ch_mask,
  input  logic [N_CH-1:0]        ch_vsync,
  input  logic [N_CH-1:0]        ch_href,
  input  logic [N_CH-1:0]        ch_clken,
  input  logic [N_CH*PIX_W-1:0]  ch_data,
  output logic                   wr_en,
  output logic [CH_W-1:0]        wr_ch,
  output logic [ADDR_W-1:0]      wr_addr,
  output logic [PIX_W-1:0]       wr_data,
  output logic                   busy,
  output logic                   done,
  output logic [N_CH-1:0]        frame_err
);

  localparam logic [ADDR_W-1:0] FRAME_PIX = ADDR_W'(IMG_HDISP * IMG_VDISP);

  state_e                   state_q, state_d;
  logic [N_CH-1:0]          mask_q, mask_d, served_q, served_d, err_q, err_d;
  logic [CH_W-1:0]          sel_q, sel_d, wr_ch_q, wr_ch_d;
  logic [ADDR_W-1:0]        cnt_q, cnt_d, wr_addr_q, wr_addr_d;
  logic [PIX_W-1:0]         wr_data_q, wr_data_d;
  logic                     busy_q, busy_d, done_q, done_d, wr_en_q, wr_en_d;
  logic [N_CH-1:0]          vs_fall;
  logic [N_CH-1:0][PIX_W-1:0] data_arr;
  logic                     beat;
  pick_t                    pick;

  vsync_fall_det u_vfd [N_CH-1:0] (
    .clk   (clk),
    .rst   (rst),
    .vsync (ch_vsync),
    .fall  (vs_fall)
  );

  assign data_arr = ch_data;
  assign beat     = ch_href[sel_q] & ch_clken[sel_q];

  always_comb begin
    state_d   = state_q;
    mask_d    = mask_q;
    served_d  = served_q;
    err_d     = err_q;
    sel_d     = sel_q;
    cnt_d     = cnt_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    wr_en_d   = 1'b0;
    wr_ch_d   = wr_ch_q;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    pick      = pick_lowest(mask_q & ~served_q);

    case (state_q)
      S_IDLE: if (start) begin
        mask_d   = ch_mask;
        served_d = '0;
        err_d    = '0;
        busy_d   = 1'b1;
        state_d  = S_SELECT;
      end
      S_SELECT: begin
        sel_d   = pick.found ? pick.idx : sel_q;
        state_d = pick.found ? S_ARM : S_FINISH;
      end
      S_ARM: if (vs_fall[sel_q]) begin
        cnt_d   = '0;
        state_d = S_CAPTURE;
      end
      S_CAPTURE: begin
        // A new vsync before the frame is complete means the source cut it short.
        if (vs_fall[sel_q]) begin
          err_d[sel_q] = 1'b1;
          state_d      = S_NEXT;
        end else if (beat && cnt_q != FRAME_PIX) begin
          wr_en_d   = 1'b1;
          wr_ch_d   = sel_q;
          wr_addr_d = cnt_q;
          wr_data_d = data_arr[sel_q];
          cnt_d     = cnt_q + ADDR_W'(1);
          if (cnt_d == FRAME_PIX) state_d = S_NEXT;
        end
      end
      S_NEXT: begin
        served_d[sel_q] = 1'b1;
        state_d         = S_SELECT;
      end
      S_FINISH: begin
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Abort drops any new write and done, but keeps the error history.
    if (abort && state_q != S_IDLE) begin
      state_d = S_IDLE;
      busy_d  = 1'b0;
      done_d  = 1'b0;
      wr_en_d = 1'b0;
      err_d   = err_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      mask_q    <= '0;
      served_q  <= '0;
      err_q     <= '0;
      sel_q     <= '0;
      cnt_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      wr_en_q   <= 1'b0;
      wr_ch_q   <= '0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
    end else begin
      state_q   <= state_d;
      mask_q    <= mask_d;
      served_q  <= served_d;
      err_q     <= err_d;
      sel_q     <= sel_d;
      cnt_q     <= cnt_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      wr_en_q   <= wr_en_d;
      wr_ch_q   <= wr_ch_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
    end
  end

  assign wr_en     = wr_en_q;
  assign wr_ch     = wr_ch_q;
  assign wr_addr   = wr_addr_q;
  assign wr_data   = wr_data_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign frame_err = err_q;

endmodule

// File: tb/tb_frame_capture_sched.sv
// Scoreboard bench for frame_capture_sched with an 8x4 frame (32 pixels).
module tb_frame_capture_sched;

  localparam int H = 8;
  localparam int V = 4;

  logic        clk = 1'b0;
  logic        rst, start, abort;
  logic [2:0]  ch_mask, ch_vsync, ch_href, ch_clken;
  logic [71:0] ch_data;
  logic        wr_en, busy, done;
  logic [1:0]  wr_ch;
  logic [18:0] wr_addr;
  logic [23:0] wr_data;
  logic [2:0]  frame_err;

  typedef struct packed {
    logic [1:0]  ch;
    logic [18:0] addr;
    logic [23:0] data;
  } wr_t;

  wr_t sb[$];
  wr_t exp_w;
  int  total = 0, bad = 0, done_cnt = 0, wr_cnt = 0, ch1_wr = 0;

  always #5 clk = ~clk;

  frame_capture_sched #(.IMG_HDISP(H), .IMG_VDISP(V)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .ch_mask(ch_mask),
    .ch_vsync(ch_vsync), .ch_href(ch_href), .ch_clken(ch_clken), .ch_data(ch_data),
    .wr_en(wr_en), .wr_ch(wr_ch), .wr_addr(wr_addr), .wr_data(wr_data),
    .busy(busy), .done(done), .frame_err(frame_err)
  );

  // Write monitor: every write must match the oldest expected beat.
  always @(negedge clk) begin
    if (done === 1'b1) done_cnt++;
    if (wr_en === 1'b1) begin
      wr_cnt++;
      if (wr_ch == 2'd1) ch1_wr++;
      total++;
      if (sb.size() == 0) begin
        bad++;
        $display("FAIL unexpected_write: got ch=%0d addr=%0d data=%h, expected no write",
                 wr_ch, wr_addr, wr_data);
      end else begin
        exp_w = sb.pop_front();
        if ({wr_ch, wr_addr, wr_data} !== exp_w) begin
          bad++;
          $display("FAIL write: got ch=%0d addr=%0d data=%h, expected ch=%0d addr=%0d data=%h",
                   wr_ch, wr_addr, wr_data, exp_w.ch, exp_w.addr, exp_w.data);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic pulse_start(input logic [2:0] m);
    ch_mask = m;
    start   = 1'b1;
    tick();
    start   = 1'b0;
  endtask

  // vsync fall, then nbeats pixels (with occasional clken stalls), optional truncating fall.
  task automatic drive_frame(input int k, input int nbeats, input bit trunc, input int poke_at);
    wr_t w;
    logic [23:0] d;
    ch_vsync[k] = 1'b0; tick(); ch_vsync[k] = 1'b1; tick();
    for (int i = 0; i < nbeats; i++) begin
      if (i % 7 == 3) begin
        ch_href[k] = 1'b1; ch_clken[k] = 1'b0; tick();
      end
      d = 24'($urandom);
      ch_href[k] = 1'b1; ch_clken[k] = 1'b1; ch_data[24*k +: 24] = d;
      w.ch = 2'(k); w.addr = 19'(i); w.data = d;
      sb.push_back(w);
      if (i == poke_at) begin
        start = 1'b1; ch_mask = 3'b111;
        ch_href[1] = 1'b1; ch_clken[1] = 1'b1; ch_data[47:24] = 24'h0BAD01;
      end
      tick();
      if (i == poke_at) begin
        start = 1'b0; ch_href[1] = 1'b0; ch_clken[1] = 1'b0;
      end
    end
    ch_href[k] = 1'b0; ch_clken[k] = 1'b0;
    if (trunc) begin
      ch_vsync[k] = 1'b0; tick(); ch_vsync[k] = 1'b1; tick();
    end
  endtask

  task automatic wait_done(input int budget, input int d0, input string name);
    int n = 0;
    while (done_cnt == d0 && n < budget) begin tick(); n++; end
    total++;
    if (done_cnt == d0) begin
      bad++;
      $display("FAIL %s_done_timeout: no done within %0d cycles", name, budget);
    end
  endtask

  task automatic check_sb_empty(input string name);
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL %s_missing_writes: %0d expected writes never seen, expected 0", name, sb.size());
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    ticks(2);
    @(negedge clk);
    total += 4;
    if (busy !== 1'b0 || done !== 1'b0) begin
      bad++; $display("FAIL reset_ctrl: busy=%b done=%b, expected 0 0", busy, done);
    end
    if (wr_en !== 1'b0 || wr_ch !== 2'd0) begin
      bad++; $display("FAIL reset_wr: wr_en=%b wr_ch=%0d, expected 0 0", wr_en, wr_ch);
    end
    if (wr_addr !== 19'd0 || wr_data !== 24'd0) begin
      bad++; $display("FAIL reset_bus: addr=%0d data=%h, expected 0 0", wr_addr, wr_data);
    end
    if (frame_err !== 3'b000) begin
      bad++; $display("FAIL reset_err: frame_err=%b, expected 000", frame_err);
    end
    tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic test_two_channels();
    int d0 = done_cnt, c1 = ch1_wr, w0 = wr_cnt;
    pulse_start(3'b101);
    ticks(3);
    drive_frame(0, 32, 1'b0, -1);
    ticks(3);
    drive_frame(2, 32, 1'b0, -1);
    wait_done(50, d0, "two_ch");
    ticks(3);
    check_sb_empty("two_ch");
    total += 5;
    if (wr_cnt - w0 != 64) begin bad++; $display("FAIL two_ch_count: got %0d writes, expected 64", wr_cnt - w0); end
    if (done_cnt - d0 != 1) begin bad++; $display("FAIL two_ch_done: got %0d done pulses, expected 1", done_cnt - d0); end
    if (frame_err !== 3'b000) begin bad++; $display("FAIL two_ch_err: frame_err=%b, expected 000", frame_err); end
    if (ch1_wr != c1) begin bad++; $display("FAIL two_ch_ch1: got %0d ch1 writes, expected 0", ch1_wr - c1); end
    if (busy !== 1'b0) begin bad++; $display("FAIL two_ch_busy: busy=%b, expected 0", busy); end
  endtask

  task automatic test_truncated();
    int d0 = done_cnt, w0 = wr_cnt;
    pulse_start(3'b010);
    ticks(3);
    drive_frame(1, 20, 1'b1, -1);
    wait_done(50, d0, "trunc");
    ticks(2);
    check_sb_empty("trunc");
    total += 2;
    if (wr_cnt - w0 != 20) begin bad++; $display("FAIL trunc_count: got %0d writes, expected 20", wr_cnt - w0); end
    if (frame_err !== 3'b010) begin bad++; $display("FAIL trunc_err: frame_err=%b, expected 010", frame_err); end
  endtask

  task automatic test_empty_mask();
    int w0 = wr_cnt;
    logic [3:0] seen;
    pulse_start(3'b000);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      seen[i] = done;
    end
    total += 2;
    if (seen !== 4'b0100) begin bad++; $display("FAIL empty_done_timing: done per cycle=%b, expected 0100", seen); end
    if (wr_cnt != w0) begin bad++; $display("FAIL empty_writes: got %0d writes, expected 0", wr_cnt - w0); end
    tick();
  endtask

  task automatic test_abort();
    int d0 = done_cnt, w0 = wr_cnt;
    pulse_start(3'b001);
    total++;
    if (frame_err !== 3'b000) begin bad++; $display("FAIL abort_err_clear: frame_err=%b, expected 000", frame_err); end
    ticks(3);
    drive_frame(0, 10, 1'b0, -1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    @(negedge clk);
    total++;
    if (busy !== 1'b0) begin bad++; $display("FAIL abort_busy: busy=%b, expected 0", busy); end
    ticks(6);
    check_sb_empty("abort");
    total += 2;
    if (wr_cnt - w0 > 11) begin bad++; $display("FAIL abort_count: got %0d writes, expected at most 11", wr_cnt - w0); end
    if (done_cnt != d0) begin bad++; $display("FAIL abort_done: got %0d done pulses, expected 0", done_cnt - d0); end
    d0 = done_cnt;
    pulse_start(3'b001);
    ticks(3);
    drive_frame(0, 32, 1'b0, -1);
    wait_done(50, d0, "restart");
    ticks(2);
    check_sb_empty("restart");
  endtask

  task automatic test_start_ignored();
    int d0 = done_cnt, c1 = ch1_wr, w0 = wr_cnt;
    pulse_start(3'b001);
    ticks(3);
    drive_frame(0, 32, 1'b0, 5);
    wait_done(50, d0, "ignore");
    ticks(10);
    check_sb_empty("ignore");
    total += 3;
    if (wr_cnt - w0 != 32) begin bad++; $display("FAIL ignore_count: got %0d writes, expected 32", wr_cnt - w0); end
    if (ch1_wr != c1) begin bad++; $display("FAIL ignore_ch1: got %0d ch1 writes, expected 0", ch1_wr - c1); end
    if (done_cnt - d0 != 1) begin bad++; $display("FAIL ignore_done: got %0d done pulses, expected 1", done_cnt - d0); end
  endtask

  task automatic test_reset_mid();
    int w0;
    pulse_start(3'b011);
    ticks(3);
    drive_frame(0, 3, 1'b1, -1);
    ticks(3);
    drive_frame(1, 8, 1'b0, -1);
    total++;
    if (frame_err !== 3'b001) begin bad++; $display("FAIL mid_err_sticky: frame_err=%b, expected 001", frame_err); end
    rst = 1'b1;
    ch_href[1] = 1'b1; ch_clken[1] = 1'b1;
    tick();
    @(negedge clk);
    w0 = wr_cnt;
    total += 3;
    if (busy !== 1'b0 || done !== 1'b0 || wr_en !== 1'b0) begin
      bad++; $display("FAIL mid_rst_ctrl: busy=%b done=%b wr_en=%b, expected 0 0 0", busy, done, wr_en);
    end
    if (wr_ch !== 2'd0 || wr_addr !== 19'd0 || wr_data !== 24'd0) begin
      bad++; $display("FAIL mid_rst_bus: ch=%0d addr=%0d data=%h, expected 0 0 0", wr_ch, wr_addr, wr_data);
    end
    if (frame_err !== 3'b000) begin bad++; $display("FAIL mid_rst_err: frame_err=%b, expected 000", frame_err); end
    tick();
    rst = 1'b0;
    ticks(4);
    ch_href[1] = 1'b0; ch_clken[1] = 1'b0;
    ticks(2);
    check_sb_empty("mid_rst");
    total++;
    if (wr_cnt != w0) begin bad++; $display("FAIL mid_rst_wr: got %0d writes after reset, expected 0", wr_cnt - w0); end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; abort = 1'b0; ch_mask = 3'b000;
    ch_vsync = 3'b111; ch_href = 3'b000; ch_clken = 3'b000; ch_data = '0;
    test_reset();
    test_two_channels();
    test_truncated();
    test_empty_mask();
    test_abort();
    test_start_ignored();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/frame_capture_sched.md
FRAME_CAPTURE_SCHED -- requirements
Module: frame_capture_sched

Interface
REQ-001 SHALL have parameter IMG_HDISP, default 640, active pixels per line.
REQ-002 SHALL have parameter IMG_VDISP, default 480, active lines per frame.
REQ-003 SHALL have port clk, input, 1, the single clock; all logic on rising edge.
REQ-004 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-005 SHALL have port start, input, 1, single-cycle request to begin a capture sequence.
REQ-006 SHALL have port abort, input, 1, single-cycle request to cancel the sequence.
REQ-007 SHALL have port ch_mask, input, 3, channels to capture, sampled at accepted start.
REQ-008 SHALL have ports ch_vsync, ch_href and ch_clken, input, 3 each, per-channel frame timing; vsync is low during sync.
REQ-009 SHALL have port ch_data, input, 72, per-channel 24-bit pixel, channel k on bits [24k+23:24k].
REQ-010 SHALL have ports wr_en (output, 1), wr_ch (output, 2), wr_addr (output, 19) and wr_data (output, 24), forming the shared frame-buffer write port.
REQ-011 SHALL have ports busy (output, 1), done (output, 1 pulse) and frame_err (output, 3, sticky per channel).

Function
REQ-012 SHALL implement FSM states IDLE, SELECT, ARM, CAPTURE, NEXT and FINISH.
REQ-013 IDLE: on start, SHALL latch ch_mask, set busy and go to SELECT; start SHALL be ignored in every other state.
REQ-014 SELECT: SHALL pick the lowest unserved channel in the latched mask and go to ARM; if none remain, SHALL go to FINISH.
REQ-015 ARM: SHALL wait for a 1->0 edge on the selected channel's vsync, clear the pixel counter and enter CAPTURE.
REQ-016 CAPTURE: each cycle with href&clken high on the selected channel is a beat; other channels SHALL be ignored.
REQ-017 Each beat SHALL give, one cycle later, wr_en=1, wr_ch=selected channel, wr_addr=pixel count before the beat and wr_data=the beat's data; there SHALL be no other write latency.
REQ-018 When the counter reaches IMG_HDISP*IMG_VDISP, CAPTURE SHALL go to NEXT; further beats SHALL NOT be written.
REQ-019 A selected-channel vsync 1->0 edge in CAPTURE before the count completes SHALL set frame_err[ch] and go to NEXT.
REQ-020 NEXT: SHALL mark the channel served and return to SELECT in one cycle.
REQ-021 FINISH: SHALL pulse done for exactly one cycle, clear busy and return to IDLE.
REQ-022 start with ch_mask=0 SHALL produce done exactly 3 cycles after start (IDLE->SELECT->FINISH), with no writes.
REQ-023 abort in any non-IDLE state SHALL go to IDLE next cycle with busy=0 and no done; a write already registered for the current cycle SHALL still complete; frame_err SHALL be kept.
REQ-024 abort and start in the same cycle while IDLE: start SHALL win.
REQ-025 The pixel counter SHALL be 19 bits and SHALL NOT wrap, because it is capped by REQ-018.
REQ-026 frame_err SHALL clear only on reset or on an accepted start.

Reset
REQ-027 On rst: state=IDLE, busy=0, done=0, wr_en=0, wr_ch=0, wr_addr=0, wr_data=0, frame_err=0, served mask=0, pixel counter=0 and vsync history=0.
REQ-028 rst asserted mid-capture SHALL take effect the next edge; no write SHALL follow that edge.

Structure
REQ-029 A shared package vip_sched_pkg SHALL hold the FSM state enumeration, N_CH=3, PIX_W=24 and ADDR_W=19.
REQ-030 A sub-module vsync_fall_det SHALL register one vsync and flag its 1->0 edge; one instance per channel.

Verification (bench params IMG_HDISP=8, IMG_VDISP=4, frame total 32)
REQ-031 start, ch_mask=3'b101 with clean frames on all channels -> 32 writes with wr_ch=0 and addresses 0..31, then 32 with wr_ch=2; done once; frame_err=0; channel 1 never written.
REQ-032 ch_mask=3'b010 with the channel-1 frame truncated after 20 beats by a vsync fall -> 20 writes at addresses 0..19, frame_err=3'b010, done asserted.
REQ-033 start with ch_mask=0 -> done exactly 3 cycles later, wr_en never high.
REQ-034 abort after 10 beats of channel 0 -> at most 11 writes, busy=0 the next cycle, no done; a following start restarts at wr_addr=0.
REQ-035 A second start during CAPTURE -> ignored, write sequence unchanged; a beat on an unselected channel -> no write.
REQ-036 rst asserted mid-capture -> all outputs at reset values the next cycle, wr_en stays 0.
